// File: rtl/mant_sqrt_iter_pkg.sv
// Shared definitions for the iterative mantissa square-root unit:
// FSM state type and the root-width helper.
package mant_sqrt_iter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } sqrt_state_t;

    function automatic int sqrt_root_w(input int mant_w, input int extra_w);
        return mant_w + 1 + extra_w;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One combinational restoring square-root iteration: brings down two radicand
// bits, trial-subtracts (root<<2)|1 and appends one root bit.
module sqrt_step #(
    parameter int R = 26
) (
    input  logic [R+1:0] rem,
    input  logic [R-1:0] root,
    input  logic [1:0]   bits,
    output logic [R+1:0] rem_nxt,
    output logic [R-1:0] root_nxt
);

    logic [R+1:0] rem_sh;
    logic [R+1:0] trial;

    // The remainder never exceeds 2*root, so the two bits dropped here are always zero.
    assign rem_sh = {rem[R-1:0], bits};
    assign trial  = {root, 2'b01};

    always_comb begin
        rem_nxt  = rem_sh;
        root_nxt = {root[R-2:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_nxt  = rem_sh - trial;
            root_nxt = {root[R-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mant_sqrt_iter.sv
// Iterative mantissa square root: one restoring step per cycle, R cycles per
// operand, single operation in flight with valid/ready on both sides.
module mant_sqrt_iter
    import mant_sqrt_iter_pkg::*;
#(
    parameter  int MANT_W  = 23,
    parameter  int EXTRA_W = 2,
    parameter  int TAG_W   = 10,
    localparam int R       = sqrt_root_w(MANT_W, EXTRA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W:0]   in_sig,
    input  logic              in_exp_odd,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [R-1:0]      out_root,
    output logic              out_sticky,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int CNT_W = $clog2(R);
    localparam int SHIFT = 2*R - 2 - MANT_W;

    sqrt_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [2*R-1:0]     rad;
    logic [R-1:0]       root;
    logic [R+1:0]       rem;
    logic [TAG_W-1:0]   tag;

    logic [2*R-1:0]     sig_ext;
    logic [2*R-1:0]     rad_init;
    logic [R+1:0]       rem_nxt;
    logic [R-1:0]       root_nxt;

    // Odd exponent doubles the radicand so the exponent halves exactly.
    assign sig_ext  = {{(2*R-MANT_W-1){1'b0}}, in_sig};
    assign rad_init = in_exp_odd ? (sig_ext << (SHIFT + 1)) : (sig_ext << SHIFT);

    sqrt_step #(.R(R)) u_step (
        .rem      (rem),
        .root     (root),
        .bits     (rad[2*R-1:2*R-2]),
        .rem_nxt  (rem_nxt),
        .root_nxt (root_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rad       <= '0;
            root      <= '0;
            rem       <= '0;
            tag       <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= CALC;
                        rad   <= rad_init;
                        root  <= '0;
                        rem   <= '0;
                        tag   <= in_tag;
                        cnt   <= CNT_W'(R - 1);
                    end
                end
                CALC: begin
                    rad  <= rad << 2;
                    root <= root_nxt;
                    rem  <= rem_nxt;
                    if (cnt == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Held low for the whole reset, ready the moment reset releases.
    assign in_ready   = (state == IDLE) && rst;
    assign out_root   = root;
    assign out_sticky = |rem;
    assign out_tag    = tag;

endmodule

// File: tb/tb_mant_sqrt_iter.sv
// Scoreboard bench for mant_sqrt_iter at the default widths (R = 26).
module tb_mant_sqrt_iter;

    localparam int MANT_W  = 23;
    localparam int EXTRA_W = 2;
    localparam int TAG_W   = 10;
    localparam int R       = MANT_W + 1 + EXTRA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [MANT_W:0]   in_sig = '0;
    logic              in_exp_odd = 1'b0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [R-1:0]      out_root;
    logic              out_sticky;
    logic [TAG_W-1:0]  out_tag;

    typedef struct {
        logic [R-1:0]     root;
        logic             sticky;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    exp_t nul;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;
    int   acc_cyc = 0;
    int   n_acc   = 0;
    int   ov_seen = 0;
    logic prev_ov = 1'b0;

    always #5 clk = ~clk;

    mant_sqrt_iter #(.MANT_W(MANT_W), .EXTRA_W(EXTRA_W), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sig     (in_sig),
        .in_exp_odd (in_exp_odd),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_root   (out_root),
        .out_sticky (out_sticky),
        .out_tag    (out_tag)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [R-1:0] root, input logic sticky, input logic [TAG_W-1:0] tg);
        exp_t e;
        e.root   = root;
        e.sticky = sticky;
        e.tag    = tg;
        return e;
    endfunction

    // Reference: greedy bit-by-bit integer square root of the scaled radicand.
    function automatic exp_t model(input logic [MANT_W:0] sig, input logic odd, input logic [TAG_W-1:0] tg);
        longint unsigned n, r, c;
        n = {40'd0, sig};
        n = odd ? (n << 28) : (n << 27);
        r = 0;
        for (int b = R - 1; b >= 0; b--) begin
            c = r | (64'd1 << b);
            if (c * c <= n) r = c;
        end
        return mk(r[R-1:0], (r * r) != n, tg);
    endfunction

    // One cycle: sample at the falling edge, score handshakes, then drive new inputs.
    task automatic cyc(input logic iv, input logic [MANT_W:0] sig, input logic odd,
                       input logic [TAG_W-1:0] tg, input logic ordy, input logic fl, input exp_t e);
        exp_t x;
        @(negedge clk);
        cyc_no++;
        if (out_valid && !prev_ov) check("latency", 64'(cyc_no - acc_cyc), 64'(R + 1));
        prev_ov = out_valid;
        if (!fl && ordy && out_valid) begin
            check("pending_result", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                x = q.pop_front();
                check("root", 64'(out_root), 64'(x.root));
                check("sticky", 64'(out_sticky), 64'(x.sticky));
                check("tag", 64'(out_tag), 64'(x.tag));
            end
        end
        if (!fl && iv && in_ready) begin
            q.push_back(e);
            acc_cyc = cyc_no;
            n_acc++;
        end
        if (fl) q.delete();
        in_valid   = iv;
        in_sig     = sig;
        in_exp_odd = odd;
        in_tag     = tg;
        out_ready  = ordy;
        flush      = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, nul);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, nul);
            n++;
        end
        check("ready_wait", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [MANT_W:0] sig, input logic odd, input logic [TAG_W-1:0] tg, input exp_t e);
        int n = 0;
        wait_ready();
        cyc(1'b1, sig, odd, tg, 1'b1, 1'b0, e);
        while (q.size() != 0 && n < 100) begin
            cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, nul);
            n++;
        end
        check("op_done", 64'(q.size()), 64'd0);
    endtask

    initial begin
        exp_t e;
        int   n;
        nul = mk('0, 1'b0, '0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_root", 64'(out_root), 64'd0);
        check("rst_sticky", 64'(out_sticky), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        rst = 1'b1;
        #1;
        check("rst_release_ready", 64'(in_ready), 64'd1);

        // Directed operands
        run_op(24'h800000, 1'b0, 10'h011, mk(26'h2000000, 1'b0, 10'h011));
        run_op(24'h800000, 1'b1, 10'h022, mk(26'h2D413CC, 1'b1, 10'h022));
        run_op(24'hC80000, 1'b0, 10'h033, mk(26'h2800000, 1'b0, 10'h033));
        run_op(24'h900000, 1'b1, 10'h044, mk(26'h3000000, 1'b0, 10'h044));
        run_op(24'hFFFFFF, 1'b1, 10'h3FF, model(24'hFFFFFF, 1'b1, 10'h3FF));

        // Back-pressure hold in DONE, with in_valid pressed against in_ready=0
        wait_ready();
        e = mk(26'h2800000, 1'b0, 10'h3A5);
        cyc(1'b1, 24'hC80000, 1'b0, 10'h3A5, 1'b0, 1'b0, e);
        n = 0;
        while (!out_valid && n < 100) begin
            cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, nul);
            n++;
        end
        check("hold_reach_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 24'h900000, 1'b1, 10'h155, 1'b0, 1'b0, nul);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_root", 64'(out_root), 64'(e.root));
            check("hold_sticky", 64'(out_sticky), 64'(e.sticky));
            check("hold_tag", 64'(out_tag), 64'(e.tag));
        end
        idle(3);
        check("hold_drained", 64'(q.size()), 64'd0);

        // Flush at iteration 10
        wait_ready();
        cyc(1'b1, 24'h800000, 1'b1, 10'h0F0, 1'b1, 1'b0, model(24'h800000, 1'b1, 10'h0F0));
        idle(9);
        cyc(1'b1, 24'hC80000, 1'b0, 10'h0F1, 1'b1, 1'b1, nul);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, nul);
        check("flush_idle", 64'(in_ready), 64'd1);
        check("flush_no_valid", 64'(out_valid), 64'd0);
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, nul);
            if (out_valid) ov_seen++;
        end
        check("flush_silent", 64'(ov_seen), 64'd0);
        run_op(24'h900000, 1'b1, 10'h0F2, mk(26'h3000000, 1'b0, 10'h0F2));

        // Reset pulse at iteration 10
        wait_ready();
        cyc(1'b1, 24'hC80000, 1'b0, 10'h1E0, 1'b1, 1'b0, model(24'hC80000, 1'b0, 10'h1E0));
        idle(10);
        rst = 1'b0;
        #1;
        q.delete();
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, nul);
        rst = 1'b1;
        #1;
        check("midrst_release_ready", 64'(in_ready), 64'd1);
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, nul);
            if (out_valid) ov_seen++;
        end
        check("midrst_silent", 64'(ov_seen), 64'd0);
        run_op(24'h800000, 1'b0, 10'h1E1, mk(26'h2000000, 1'b0, 10'h1E1));

        // Random back-to-back traffic with random back-pressure
        n_acc = 0;
        n = 0;
        while (n_acc < 1000 && n < 80000) begin
            logic [MANT_W:0]  s;
            logic             o;
            logic [TAG_W-1:0] t;
            s = {1'b1, 23'($urandom)};
            o = 1'($urandom_range(0, 1));
            t = TAG_W'($urandom);
            cyc($urandom_range(0, 3) != 0, s, o, t, 1'($urandom_range(0, 1)), 1'b0, model(s, o, t));
            n++;
        end
        check("random_accepted", 64'(n_acc), 64'd1000);
        n = 0;
        while (q.size() != 0 && n < 200) begin
            cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, nul);
            n++;
        end
        check("random_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
